// File: rtl/eiu_pkg.sv
// Shared definitions for the exception/interrupt unit: cause codes, FSM states,
// mtvec modes and the trap-vector computation.
package eiu_pkg;

  localparam logic [3:0] EXC_INST_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL       = 4'd2;
  localparam logic [3:0] EXC_EBREAK        = 4'd3;
  localparam logic [3:0] EXC_LD_MISALIGN   = 4'd4;
  localparam logic [3:0] EXC_ST_MISALIGN   = 4'd6;
  localparam logic [3:0] EXC_ECALL         = 4'd11;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAP,
    ST_MRET,
    ST_REDIR
  } eiu_state_e;

  // Vectored mode only offsets interrupts; a zero mtvec falls back to reset_pc.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        irq,
                                              input logic [3:0]  code,
                                              input logic [31:0] reset_pc);
    logic [31:0] tgt;
    tgt = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == MTVEC_VECTORED && irq)
      tgt = tgt + {26'b0, code, 2'b00};
    if (mtvec == '0)
      tgt = reset_pc;
    return tgt;
  endfunction

endpackage

// File: rtl/eiu_cause_enc.sv
// Combinational trap-cause priority encoder: interrupts first, then exceptions.
module eiu_cause_enc
  import eiu_pkg::*;
(
  input  logic [2:0] irq_pend,     // {MEI, MTI, MSI}
  input  logic       mstatus_mie,
  input  logic       exc_inst_misalign,
  input  logic       exc_illegal,
  input  logic       exc_ebreak,
  input  logic       exc_ecall,
  input  logic       exc_ld_misalign,
  input  logic       exc_st_misalign,
  output logic       take,
  output logic       is_irq,
  output logic [3:0] code
);

  always_comb begin
    take   = 1'b0;
    is_irq = 1'b0;
    code   = '0;
    if (mstatus_mie && (irq_pend != 3'b000)) begin
      take   = 1'b1;
      is_irq = 1'b1;
      if (irq_pend[2])      code = IRQ_MEI;
      else if (irq_pend[0]) code = IRQ_MSI;
      else                  code = IRQ_MTI;
    end else begin
      take = 1'b1;
      if (exc_inst_misalign)    code = EXC_INST_MISALIGN;
      else if (exc_illegal)     code = EXC_ILLEGAL;
      else if (exc_ebreak)      code = EXC_EBREAK;
      else if (exc_ecall)       code = EXC_ECALL;
      else if (exc_ld_misalign) code = EXC_LD_MISALIGN;
      else if (exc_st_misalign) code = EXC_ST_MISALIGN;
      else                      take = 1'b0;
    end
  end

endmodule

// File: rtl/eiu.sv
// Exception/interrupt unit: synchronises interrupt lines, arbitrates traps at
// commit and sequences CSR strobes and the fetch redirect through a small FSM.
module eiu
  import eiu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_irq,
  input  logic        time_irq,
  input  logic        soft_irq,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic [31:0] commit_mem_addr,
  input  logic        exc_inst_misalign,
  input  logic        exc_illegal,
  input  logic        exc_ebreak,
  input  logic        exc_ecall,
  input  logic        exc_ld_misalign,
  input  logic        exc_st_misalign,
  input  logic        is_mret,
  input  logic [31:0] mstatus_r,
  input  logic [31:0] mie_r,
  input  logic [31:0] mtvec_r,
  input  logic [31:0] mepc_r,
  output logic        trap_en,
  output logic        mret_commit,
  output logic [31:0] mepc_from_eiu,
  output logic [31:0] mcause_from_eiu,
  output logic [31:0] mtval_from_eiu,
  output logic        inst_finish,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic [SYNC_STAGES:0]   ext_chain;
  logic                   time_q, soft_q;

  assign ext_chain = {ext_sync_q, ext_irq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_sync_q <= '0;
      time_q     <= 1'b0;
      soft_q     <= 1'b0;
    end else begin
      ext_sync_q <= ext_chain[SYNC_STAGES-1:0];
      time_q     <= time_irq;
      soft_q     <= soft_irq;
    end
  end

  logic [2:0] irq_pend;
  logic       take, is_irq;
  logic [3:0] code;

  assign irq_pend = {ext_chain[SYNC_STAGES] & mie_r[11],
                     time_q & mie_r[7],
                     soft_q & mie_r[3]};

  eiu_cause_enc u_cause_enc (
    .irq_pend          (irq_pend),
    .mstatus_mie       (mstatus_r[3]),
    .exc_inst_misalign (exc_inst_misalign),
    .exc_illegal       (exc_illegal),
    .exc_ebreak        (exc_ebreak),
    .exc_ecall         (exc_ecall),
    .exc_ld_misalign   (exc_ld_misalign),
    .exc_st_misalign   (exc_st_misalign),
    .take              (take),
    .is_irq            (is_irq),
    .code              (code)
  );

  logic [31:0] mtval_d;

  always_comb begin
    mtval_d = '0;
    if (!is_irq) begin
      case (code)
        EXC_INST_MISALIGN:                mtval_d = commit_pc;
        EXC_ILLEGAL:                      mtval_d = commit_inst;
        EXC_LD_MISALIGN, EXC_ST_MISALIGN: mtval_d = commit_mem_addr;
        default:                          mtval_d = '0;
      endcase
    end
  end

  eiu_state_e  state_q;
  logic        commit_ready_q, trap_en_q, mret_q, flush_q, redirect_valid_q;
  logic [31:0] redirect_pc_q, mepc_q, mtval_q;
  logic        irq_q;
  logic [3:0]  code_q;
  logic        idle_accept;

  assign idle_accept = (state_q == ST_IDLE) && commit_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      commit_ready_q   <= 1'b1;
      trap_en_q        <= 1'b0;
      mret_q           <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mepc_q           <= '0;
      mtval_q          <= '0;
      irq_q            <= 1'b0;
      code_q           <= '0;
    end else begin
      trap_en_q <= 1'b0;
      mret_q    <= 1'b0;
      flush_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (commit_valid && take) begin
            mepc_q         <= {commit_pc[31:2], 2'b00};
            mtval_q        <= mtval_d;
            irq_q          <= is_irq;
            code_q         <= code;
            trap_en_q      <= 1'b1;
            flush_q        <= 1'b1;
            commit_ready_q <= 1'b0;
            state_q        <= ST_TRAP;
          end else if (commit_valid && is_mret) begin
            mret_q         <= 1'b1;
            flush_q        <= 1'b1;
            commit_ready_q <= 1'b0;
            state_q        <= ST_MRET;
          end
        end
        ST_TRAP: begin
          redirect_pc_q    <= trap_target(mtvec_r, irq_q, code_q, RESET_PC);
          redirect_valid_q <= 1'b1;
          state_q          <= ST_REDIR;
        end
        ST_MRET: begin
          redirect_pc_q    <= mepc_r;
          redirect_valid_q <= 1'b1;
          state_q          <= ST_REDIR;
        end
        ST_REDIR: begin
          if (redirect_ready) begin
            redirect_valid_q <= 1'b0;
            commit_ready_q   <= 1'b1;
            state_q          <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Retirement is reported in the accept cycle itself; trapped instructions never retire.
  assign inst_finish     = idle_accept && !take;
  assign commit_ready    = commit_ready_q;
  assign trap_en         = trap_en_q;
  assign mret_commit     = mret_q;
  assign flush           = flush_q;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_pc     = redirect_pc_q;
  assign mepc_from_eiu   = mepc_q;
  assign mcause_from_eiu = {irq_q, 27'b0, code_q};
  assign mtval_from_eiu  = mtval_q;

  logic unused_bits;
  assign unused_bits = ^{mstatus_r[31:4], mstatus_r[2:0], mie_r[31:12], mie_r[10:8],
                         mie_r[6:4], mie_r[2:0]};

endmodule

// File: tb/tb_eiu.sv
// Directed bench for eiu: a table of commit scenarios plus reset and
// synchroniser sequences, all checked on the falling clock edge.
module tb_eiu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ext_irq = 1'b0, time_irq = 1'b0, soft_irq = 1'b0;
  logic        commit_valid = 1'b0;
  logic        commit_ready;
  logic [31:0] commit_pc = '0, commit_inst = '0, commit_mem_addr = '0;
  logic        exc_inst_misalign = 1'b0, exc_illegal = 1'b0, exc_ebreak = 1'b0;
  logic        exc_ecall = 1'b0, exc_ld_misalign = 1'b0, exc_st_misalign = 1'b0;
  logic        is_mret = 1'b0;
  logic [31:0] mstatus_r = '0, mie_r = '0, mtvec_r = '0, mepc_r = '0;
  logic        trap_en, mret_commit, inst_finish, flush, redirect_valid;
  logic [31:0] mepc_from_eiu, mcause_from_eiu, mtval_from_eiu, redirect_pc;
  logic        redirect_ready = 1'b0;

  eiu #(.SYNC_STAGES(2), .RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ext_irq           (ext_irq),
    .time_irq          (time_irq),
    .soft_irq          (soft_irq),
    .commit_valid      (commit_valid),
    .commit_ready      (commit_ready),
    .commit_pc         (commit_pc),
    .commit_inst       (commit_inst),
    .commit_mem_addr   (commit_mem_addr),
    .exc_inst_misalign (exc_inst_misalign),
    .exc_illegal       (exc_illegal),
    .exc_ebreak        (exc_ebreak),
    .exc_ecall         (exc_ecall),
    .exc_ld_misalign   (exc_ld_misalign),
    .exc_st_misalign   (exc_st_misalign),
    .is_mret           (is_mret),
    .mstatus_r         (mstatus_r),
    .mie_r             (mie_r),
    .mtvec_r           (mtvec_r),
    .mepc_r            (mepc_r),
    .trap_en           (trap_en),
    .mret_commit       (mret_commit),
    .mepc_from_eiu     (mepc_from_eiu),
    .mcause_from_eiu   (mcause_from_eiu),
    .mtval_from_eiu    (mtval_from_eiu),
    .inst_finish       (inst_finish),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .redirect_ready    (redirect_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // kind: 0 = normal retire, 1 = trap, 2 = mret
  typedef struct {
    logic [31:0] pc, inst, addr;
    logic [5:0]  exc;      // {inst_mis, illegal, ebreak, ecall, ld_mis, st_mis}
    logic        mret;
    logic [2:0]  irq;      // {ext, time, soft}
    logic [31:0] mstatus, mie, mtvec, mepc;
    int          stall, kind;
    logic [31:0] e_mepc, e_mcause, e_mtval, e_rpc;
  } vec_t;

  function automatic vec_t mk(logic [31:0] pc, logic [31:0] inst, logic [31:0] addr,
                              logic [5:0] exc, logic mret, logic [2:0] irq,
                              logic [31:0] mstatus, logic [31:0] mie, logic [31:0] mtvec,
                              logic [31:0] mepc, int stall, int kind,
                              logic [31:0] e_mepc, logic [31:0] e_mcause,
                              logic [31:0] e_mtval, logic [31:0] e_rpc);
    vec_t v;
    v.pc = pc; v.inst = inst; v.addr = addr; v.exc = exc; v.mret = mret; v.irq = irq;
    v.mstatus = mstatus; v.mie = mie; v.mtvec = mtvec; v.mepc = mepc;
    v.stall = stall; v.kind = kind;
    v.e_mepc = e_mepc; v.e_mcause = e_mcause; v.e_mtval = e_mtval; v.e_rpc = e_rpc;
    return v;
  endfunction

  vec_t vecs[13];

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    mstatus_r = v.mstatus; mie_r = v.mie; mtvec_r = v.mtvec; mepc_r = v.mepc;
    {ext_irq, time_irq, soft_irq} = v.irq;
    repeat (3) @(negedge clk);
    commit_valid = 1'b1; commit_pc = v.pc; commit_inst = v.inst; commit_mem_addr = v.addr;
    {exc_inst_misalign, exc_illegal, exc_ebreak, exc_ecall, exc_ld_misalign, exc_st_misalign} = v.exc;
    is_mret = v.mret;
    #1;
    chk($sformatf("v%0d commit_ready", idx), commit_ready, 1);
    chk($sformatf("v%0d inst_finish", idx), inst_finish, v.kind != 1);
    @(negedge clk);
    commit_valid = 1'b0; is_mret = 1'b0;
    {exc_inst_misalign, exc_illegal, exc_ebreak, exc_ecall, exc_ld_misalign, exc_st_misalign} = '0;
    chk($sformatf("v%0d trap_en", idx), trap_en, v.kind == 1);
    chk($sformatf("v%0d mret_commit", idx), mret_commit, v.kind == 2);
    chk($sformatf("v%0d flush", idx), flush, v.kind != 0);
    chk($sformatf("v%0d ready_after", idx), commit_ready, v.kind == 0);
    if (v.kind != 0) begin
      @(negedge clk);
      chk($sformatf("v%0d redirect_valid", idx), redirect_valid, 1);
      chk($sformatf("v%0d redirect_pc", idx), redirect_pc, v.e_rpc);
      chk($sformatf("v%0d strobes_redir", idx), {trap_en, mret_commit, flush}, 0);
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        chk($sformatf("v%0d stall%0d valid", idx, s), redirect_valid, 1);
        chk($sformatf("v%0d stall%0d pc", idx, s), redirect_pc, v.e_rpc);
        chk($sformatf("v%0d stall%0d ready", idx, s), commit_ready, 0);
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
      chk($sformatf("v%0d ready_idle", idx), commit_ready, 1);
      chk($sformatf("v%0d redirect_drop", idx), redirect_valid, 0);
    end
    chk($sformatf("v%0d mepc", idx), mepc_from_eiu, v.e_mepc);
    chk($sformatf("v%0d mcause", idx), mcause_from_eiu, v.e_mcause);
    chk($sformatf("v%0d mtval", idx), mtval_from_eiu, v.e_mtval);
    {ext_irq, time_irq, soft_irq} = 3'b000;
    $display("vec %0d pc=%h kind=%0d mcause=%h redirect_pc=%h", idx, v.pc, v.kind,
             mcause_from_eiu, redirect_pc);
  endtask

  initial begin
    vecs[0]  = mk(32'h40, 32'hFFFF_FFFF, 0, 6'b010000, 0, 3'b000, 0, 0, 32'h100, 0, 5, 1,
                  32'h40, 32'h2, 32'hFFFF_FFFF, 32'h100);
    vecs[1]  = mk(32'h80, 32'h13, 0, 6'b000000, 0, 3'b010, 32'h8, 32'h80, 32'h201, 0, 0, 1,
                  32'h80, 32'h8000_0007, 0, 32'h21C);
    vecs[2]  = mk(32'h10, 32'h73, 0, 6'b000100, 0, 3'b111, 32'h8, 32'h888, 32'h100, 0, 0, 1,
                  32'h10, 32'h8000_000B, 0, 32'h100);
    vecs[3]  = mk(32'h20, 32'h3020_0073, 0, 6'b000000, 1, 3'b000, 32'h8, 0, 32'h100, 32'h1234, 0, 2,
                  32'h10, 32'h8000_000B, 0, 32'h1234);
    vecs[4]  = mk(32'h300, 32'h13, 0, 6'b000000, 0, 3'b000, 32'h8, 32'h888, 32'h100, 0, 0, 0,
                  32'h10, 32'h8000_000B, 0, 0);
    vecs[5]  = mk(32'h50, 32'h3, 32'h1003, 6'b000011, 0, 3'b000, 0, 0, 32'h0, 0, 0, 1,
                  32'h50, 32'h4, 32'h1003, 32'h0);
    vecs[6]  = mk(32'h60, 32'h23, 32'h2002, 6'b000001, 0, 3'b000, 0, 0, 32'h101, 0, 0, 1,
                  32'h60, 32'h6, 32'h2002, 32'h100);
    vecs[7]  = mk(32'h72, 32'h13, 0, 6'b110000, 0, 3'b000, 0, 0, 32'h400, 0, 0, 1,
                  32'h70, 32'h0, 32'h72, 32'h400);
    vecs[8]  = mk(32'h90, 32'h0010_0073, 0, 6'b001100, 0, 3'b000, 0, 0, 32'h400, 0, 0, 1,
                  32'h90, 32'h3, 0, 32'h400);
    vecs[9]  = mk(32'hA0, 32'h73, 0, 6'b000100, 0, 3'b010, 32'h0, 32'h80, 32'h201, 0, 0, 1,
                  32'hA0, 32'hB, 0, 32'h200);
    vecs[10] = mk(32'hB0, 32'h3020_0073, 0, 6'b000000, 1, 3'b001, 32'h8, 32'h8, 32'h201, 32'h5555, 0, 1,
                  32'hB0, 32'h8000_0003, 0, 32'h20C);
    vecs[11] = mk(32'hC0, 32'h13, 0, 6'b000000, 0, 3'b100, 32'h8, 32'h80, 32'h201, 0, 0, 0,
                  32'hB0, 32'h8000_0003, 0, 0);
    vecs[12] = mk(32'hD0, 32'h13, 0, 6'b000000, 0, 3'b110, 32'h8, 32'h880, 32'h301, 0, 0, 1,
                  32'hD0, 32'h8000_000B, 0, 32'h32C);

    // Reset state
    #12;
    chk("rst commit_ready", commit_ready, 1);
    chk("rst strobes", {trap_en, mret_commit, flush, redirect_valid, inst_finish}, 0);
    chk("rst redirect_pc", redirect_pc, 0);
    chk("rst mcause", mcause_from_eiu, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset asserted while in TRAP: everything clears at once and no strobe follows
    @(negedge clk);
    mtvec_r = 32'h100;
    commit_valid = 1'b1; commit_pc = 32'hF0; commit_inst = 32'hDEAD_BEEF; exc_illegal = 1'b1;
    @(posedge clk);
    #2;
    commit_valid = 1'b0; exc_illegal = 1'b0;
    chk("midtrap trap_en", trap_en, 1);
    rst_n = 1'b0;
    #1;
    chk("midtrap rst strobes", {trap_en, flush, redirect_valid, mret_commit}, 0);
    chk("midtrap rst ready", commit_ready, 1);
    chk("midtrap rst mepc", mepc_from_eiu, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst c%0d", c), {trap_en, redirect_valid, flush}, 0);
    end
    $display("seq reset_mid_trap done");

    // ext_irq needs two clocks through the synchroniser before it is taken
    mstatus_r = 32'h8; mie_r = 32'h800; mtvec_r = 32'h100;
    ext_irq = 1'b1;
    commit_valid = 1'b1; commit_pc = 32'hE0; commit_inst = 32'h13;
    #1;
    chk("sync c0 inst_finish", inst_finish, 1);
    @(negedge clk);
    chk("sync c1 inst_finish", inst_finish, 1);
    chk("sync c1 trap_en", trap_en, 0);
    @(negedge clk);
    chk("sync c2 inst_finish", inst_finish, 0);
    @(negedge clk);
    commit_valid = 1'b0; ext_irq = 1'b0;
    chk("sync trap_en", trap_en, 1);
    @(negedge clk);
    chk("sync redirect_valid", redirect_valid, 1);
    chk("sync redirect_pc", redirect_pc, 32'h100);
    chk("sync mcause", mcause_from_eiu, 32'h8000_000B);
    chk("sync mepc", mepc_from_eiu, 32'hE0);
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    chk("sync ready_idle", commit_ready, 1);
    $display("seq ext_irq_sync done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eiu.md
Name: eiu

Overview:
- Exception/interrupt unit: sequences the machine-mode CSR file on traps and mret.
- Sits between the commit stage and the CSR block:
  - watches the committing instruction and the interrupt lines;
  - drives trap_en, mepc/mcause/mtval_from_eiu, mret_commit and inst_finish into the CSR block;
  - issues a PC redirect/flush to fetch.
- Serialises trap entry and return through a small FSM so the CSR update and redirect never overlap.

Parameters:
- SYNC_STAGES, 2, flops in the ext_irq synchroniser (time_irq/soft_irq get a single register stage).
- RESET_PC, 32'h0000_0000, redirect target if mtvec reads 0 (bring-up safety).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ext_irq  in  1  external interrupt, asynchronous
- time_irq  in  1  timer interrupt
- soft_irq  in  1  software interrupt
- commit_valid  in  1  instruction at commit stage
- commit_ready  out  1  EIU accepts commit (low while FSM busy)
- commit_pc  in  32  PC of committing instruction
- commit_inst  in  32  instruction bits
- commit_mem_addr  in  32  load/store effective address
- exc_inst_misalign  in  1  fetch target misaligned
- exc_illegal  in  1  illegal instruction
- exc_ebreak  in  1  ebreak
- exc_ecall  in  1  ecall
- exc_ld_misalign  in  1  load address misaligned
- exc_st_misalign  in  1  store address misaligned
- is_mret  in  1  committing instruction is mret
- mstatus_r  in  32  from CSR
- mie_r  in  32  from CSR
- mtvec_r  in  32  from CSR
- mepc_r  in  32  from CSR
- trap_en  out  1  one-cycle CSR trap-write strobe
- mret_commit  out  1  one-cycle CSR mret strobe
- mepc_from_eiu  out  32  trap PC, bits[1:0]=0
- mcause_from_eiu  out  32  {irq, 27'b0, code[3:0]}
- mtval_from_eiu  out  32  trap value
- inst_finish  out  1  instruction retired (for minstret)
- flush  out  1  kill younger pipeline stages
- redirect_valid  out  1  new fetch PC valid
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepted redirect

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE; synchronisers cleared.
  - All outputs 0 except commit_ready=1.
  - Reset mid-sequence abandons it; no partial CSR strobe follows.
- Interrupt pending:
  - irq_pend = {MEI: ext_sync & mie_r[11], MTI: time_q & mie_r[7], MSI: soft_q & mie_r[3]}.
  - Taken only if mstatus_r[3]=1.
  - Priority MEI(11) > MSI(3) > MTI(7).
- Exception priority (same cycle): inst_misalign(0) > illegal(2) > ebreak(3) > ecall(11) > ld_misalign(4) > st_misalign(6).
- Interrupts beat exceptions: they are taken at the instruction boundary.
- Accept event = commit_valid & commit_ready, in IDLE only. On accept, exactly one of:
  - Interrupt pending:
    - latch mepc=commit_pc, mcause={1,code}, mtval=0;
    - instruction not retired (inst_finish=0); go to TRAP.
  - Else exception:
    - latch mepc=commit_pc, mcause={0,code};
    - mtval = commit_pc (code 0), commit_inst (2), commit_mem_addr (4/6), else 0;
    - inst_finish=0; go to TRAP.
  - Else is_mret: inst_finish=1; go to MRET.
  - Else normal: inst_finish=1 same cycle, stay IDLE.
- TRAP (1 cycle):
  - trap_en=1, flush=1, commit_ready=0.
  - Compute target:
    - mtvec_r[1:0]==01 and interrupt → {mtvec_r[31:2],2'b0} + 4*code;
    - otherwise → {mtvec_r[31:2],2'b0};
    - RESET_PC if mtvec_r==0.
  - Go to REDIR.
- MRET (1 cycle):
  - mret_commit=1, flush=1, commit_ready=0.
  - target = mepc_r sampled this cycle; go to REDIR.
- REDIR:
  - redirect_valid=1, redirect_pc held stable, commit_ready=0.
  - On redirect_ready go to IDLE; no timeout.
- Cycle timing:
  - trap_en/mret_commit assert exactly one cycle after accept.
  - redirect_valid is first seen two cycles after accept.
- Strobe exclusivity:
  - trap_en and mret_commit never both high.
  - Neither is high outside TRAP/MRET.
- mepc_from_eiu/mcause/mtval are registered and held until the next accept.
- Interrupts arriving while not IDLE wait; they are re-evaluated at the next accept.
- mret with a simultaneous pending enabled interrupt: the interrupt wins; mret is not executed.

Decomposition:
- defines.v additions:
  - cause codes (EXC_* / IRQ_*);
  - FSM state encodings IDLE/TRAP/MRET/REDIR;
  - mtvec mode values.
- One sub-module eiu_cause_enc (combinational): takes irq_pend, exception flags and mstatus.MIE; outputs take, is_irq, code[3:0].
- Synchroniser and FSM stay in eiu.

Test Plan:
- mtvec=0x100 (direct), exc_illegal at pc 0x40, inst 0xFFFFFFFF → trap_en 1 cycle later, mepc=0x40, mcause=0x2, mtval=0xFFFFFFFF, redirect_pc=0x100, inst_finish=0.
- mtvec=0x201 (vectored), mie=0x080, MIE=1, time_irq high, normal commit at 0x80 → mcause=0x80000007, redirect_pc=0x21C, mepc=0x80.
- ext_irq+soft_irq+time_irq all pending and enabled, plus exc_ecall at pc 0x10 → mcause=0x8000000B, mtval=0.
- is_mret with mepc_r=0x1234, no irq → mret_commit pulse, redirect_pc=0x1234, inst_finish=1.
- redirect_ready held low 5 cycles → redirect_valid/redirect_pc stable, commit_ready=0 throughout; IDLE the cycle after ready.
- rst_n low during TRAP → all strobes 0 immediately; no trap_en after release; ext_irq ignored until SYNC_STAGES cycles after assertion.
